// File: rtl/mac_tile_engine.sv
// -----------------------------------------------------------------------------
// mac_tile_engine
//
// Computes the saturated matrix product O[M x T] = I[M x N] * W[N x T].
// I and W come from two read-only word memories and O goes to a packed output
// memory. One memory word holds LANES signed elements of DW bits, with lane 0
// at the LSB. Rows of I, transposed columns of W, and rows of O all take KW
// words each.
//
// Ports:
//   CLK, RSTN       clock and asynchronous active-low reset
//   START           start request, only looked at while idle
//   ABORT           synchronous abort, returns to idle on the next edge
//   MNT             {M, N, T} dimensions, with M in the MSBs
//   BUSY            high while an operation is running
//   DONE            one-cycle completion pulse
//   ERR             qualifies DONE and flags a dimension error
//   EN_I/ADDR_I     input memory read port; RDATA_I arrives one cycle later
//   EN_W/ADDR_W     weight memory read port; RDATA_W arrives one cycle later
//   EN_O/RW_O       output memory enable and write strobe
//   ADDR_O/WDATA_O  output memory word address and data
// -----------------------------------------------------------------------------
module mac_tile_engine #(
    parameter int DW     = 16,
    parameter int LANES  = 4,
    parameter int MAXDIM = 8,
    parameter int DIMW   = 4,
    localparam int KW    = MAXDIM / LANES,
    localparam int AW    = $clog2(MAXDIM * KW)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [3*DIMW-1:0]     MNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  EN_I,
    output logic [AW-1:0]         ADDR_I,
    input  logic [LANES*DW-1:0]   RDATA_I,
    output logic                  EN_W,
    output logic [AW-1:0]         ADDR_W,
    input  logic [LANES*DW-1:0]   RDATA_W,
    output logic                  EN_O,
    output logic                  RW_O,
    output logic [AW-1:0]         ADDR_O,
    output logic [LANES*DW-1:0]   WDATA_O
);

    localparam int ACCW = 2*DW + $clog2(MAXDIM);

    // Saturation limits, sign-extended to the accumulator width.
    localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_FIN
    } engineState_t;

    engineState_t state_q, state_d;

    logic [DIMW-1:0]        dimM_q, dimM_d;
    logic [DIMW-1:0]        dimN_q, dimN_d;
    logic [DIMW-1:0]        dimT_q, dimT_d;
    logic [DIMW-1:0]        mIdx_q, mIdx_d;
    logic [DIMW-1:0]        tIdx_q, tIdx_d;
    logic [DIMW-1:0]        bIdx_q, bIdx_d;
    logic [DIMW-1:0]        prevB_q, prevB_d;
    logic                   rdValid_q, rdValid_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [LANES*DW-1:0]    buf_q, buf_d;
    logic                   err_q, err_d;

    logic [DIMW-1:0]        fieldM, fieldN, fieldT;
    logic                   dimsOk;
    logic [DIMW-1:0]        kbLast;
    logic                   tIsLast, mIsLast, tLaneLast;
    logic signed [DW-1:0]   opI, opW;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] dotSum, accSum;
    logic [DW-1:0]          satVal;

    assign fieldM = MNT[3*DIMW-1 -: DIMW];
    assign fieldN = MNT[2*DIMW-1 -: DIMW];
    assign fieldT = MNT[DIMW-1:0];

    assign dimsOk = (fieldM != '0) && (int'(fieldM) <= MAXDIM) &&
                    (fieldN != '0) && (int'(fieldN) <= MAXDIM) &&
                    (fieldT != '0) && (int'(fieldT) <= MAXDIM);

    // Index of the last k-block of a dot product, i.e. ceil(N/LANES)-1.
    assign kbLast    = DIMW'((int'(dimN_q) + LANES - 1) / LANES - 1);
    assign tIsLast   = (tIdx_q == dimT_q - DIMW'(1));
    assign mIsLast   = (mIdx_q == dimM_q - DIMW'(1));
    assign tLaneLast = ((int'(tIdx_q) % LANES) == LANES - 1);

    // Lane products of the data returned for the previous cycle's read.
    // Lanes whose k index is at or past N are forced to zero, so memory
    // contents past the end of a row never reach the sum.
    always_comb begin
        dotSum = '0;
        opI    = '0;
        opW    = '0;
        prod   = '0;
        for (int j = 0; j < LANES; j++) begin
            opI  = RDATA_I[j*DW +: DW];
            opW  = RDATA_W[j*DW +: DW];
            prod = (2*DW)'(opI) * (2*DW)'(opW);
            if (int'(prevB_q) * LANES + j < int'(dimN_q)) begin
                dotSum = dotSum + ACCW'(prod);
            end
        end
    end

    // The running sum including this cycle's arriving data. In LAST this is
    // the complete dot product.
    assign accSum = acc_q + (rdValid_q ? dotSum : '0);

    // Clamp the wide dot product into the signed element range.
    always_comb begin
        if (accSum > SAT_HI) begin
            satVal = {1'b0, {(DW-1){1'b1}}};
        end else if (accSum < SAT_LO) begin
            satVal = {1'b1, {(DW-1){1'b0}}};
        end else begin
            satVal = accSum[DW-1:0];
        end
    end

    // Next-state logic and Moore outputs. Every enable and address depends
    // only on the registered state, so the reset state drives every output
    // to zero.
    always_comb begin
        state_d   = state_q;
        dimM_d    = dimM_q;
        dimN_d    = dimN_q;
        dimT_d    = dimT_q;
        mIdx_d    = mIdx_q;
        tIdx_d    = tIdx_q;
        bIdx_d    = bIdx_q;
        acc_d     = acc_q;
        buf_d     = buf_q;
        err_d     = err_q;
        rdValid_d = (state_q == S_READ);
        prevB_d   = bIdx_q;

        BUSY    = 1'b0;
        DONE    = 1'b0;
        ERR     = 1'b0;
        EN_I    = 1'b0;
        ADDR_I  = '0;
        EN_W    = 1'b0;
        ADDR_W  = '0;
        EN_O    = 1'b0;
        RW_O    = 1'b0;
        ADDR_O  = '0;
        WDATA_O = '0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    if (dimsOk) begin
                        dimM_d  = fieldM;
                        dimN_d  = fieldN;
                        dimT_d  = fieldT;
                        mIdx_d  = '0;
                        tIdx_d  = '0;
                        bIdx_d  = '0;
                        acc_d   = '0;
                        buf_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_READ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end

            S_READ: begin
                BUSY   = 1'b1;
                EN_I   = 1'b1;
                EN_W   = 1'b1;
                ADDR_I = AW'(int'(mIdx_q) * KW + int'(bIdx_q));
                ADDR_W = AW'(int'(tIdx_q) * KW + int'(bIdx_q));
                acc_d  = accSum;
                if (bIdx_q == kbLast) begin
                    state_d = S_LAST;
                end else begin
                    bIdx_d = bIdx_q + DIMW'(1);
                end
            end

            S_LAST: begin
                BUSY = 1'b1;
                for (int j = 0; j < LANES; j++) begin
                    if (j == int'(tIdx_q) % LANES) begin
                        buf_d[j*DW +: DW] = satVal;
                    end
                end
                acc_d  = '0;
                bIdx_d = '0;
                if (tLaneLast || tIsLast) begin
                    state_d = S_WRITE;
                end else begin
                    tIdx_d  = tIdx_q + DIMW'(1);
                    state_d = S_READ;
                end
            end

            S_WRITE: begin
                // Lanes past T-1 are still zero because the buffer is
                // cleared after every write.
                BUSY    = 1'b1;
                EN_O    = 1'b1;
                RW_O    = 1'b1;
                ADDR_O  = AW'(int'(mIdx_q) * KW + int'(tIdx_q) / LANES);
                WDATA_O = buf_q;
                buf_d   = '0;
                if (!tIsLast) begin
                    tIdx_d  = tIdx_q + DIMW'(1);
                    state_d = S_READ;
                end else if (!mIsLast) begin
                    mIdx_d  = mIdx_q + DIMW'(1);
                    tIdx_d  = '0;
                    state_d = S_READ;
                end else begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                DONE    = 1'b1;
                ERR     = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition except staying idle.
        if (ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            dimM_q    <= '0;
            dimN_q    <= '0;
            dimT_q    <= '0;
            mIdx_q    <= '0;
            tIdx_q    <= '0;
            bIdx_q    <= '0;
            prevB_q   <= '0;
            rdValid_q <= 1'b0;
            acc_q     <= '0;
            buf_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dimM_q    <= dimM_d;
            dimN_q    <= dimN_d;
            dimT_q    <= dimT_d;
            mIdx_q    <= mIdx_d;
            tIdx_q    <= tIdx_d;
            bIdx_q    <= bIdx_d;
            prevB_q   <= prevB_d;
            rdValid_q <= rdValid_d;
            acc_q     <= acc_d;
            buf_q     <= buf_d;
            err_q     <= err_d;
        end
    end

endmodule
